// File: rtl/cram_arbiter.sv
// Three-requester arbiter for one BSRAM: round-robin grant with bus lock; cram_* registered one cycle after accept.
// Backpressure via combinational req_ready; read data strobed RD_LAT cycles after the BSRAM cycle.
module cram_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        work_clk,
    input  logic        rst_n,
    input  logic [2:0]  req_valid,
    input  logic [2:0]  req_we,
    input  logic [2:0]  req_lock,
    input  logic [23:0] req_addr,
    input  logic [23:0] req_wdata,
    output logic [2:0]  req_ready,
    output logic [2:0]  rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        cram_ce,
    output logic        cram_wre,
    output logic [7:0]  cram_addrin,
    output logic [7:0]  cram_datain,
    input  logic [7:0]  cram_dataout,
    output logic        busy
);

    typedef enum logic {ST_ARB, ST_OWNED} state_t;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  rr_ptr_q;
    logic        ce_q, wre_q;
    logic [7:0]  addr_q, data_q;
    logic [1:0]  cram_idx_q;
    logic [RD_LAT-1:0] pend_vld_q;
    logic [1:0]  pend_idx_q [RD_LAT];

    logic [1:0]  cand0, cand1, cand2, grant_idx;
    logic        accept, lock_sel, we_sel, owner_lock;
    logic [7:0]  addr_sel, wdata_sel;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [2:0] oh3(input logic [1:0] v);
        return 3'b001 << v;
    endfunction

    always_comb begin
        req_ready = 3'b000;
        grant_idx = 2'd0;
        cand0     = rr_ptr_q;
        cand1     = inc3(cand0);
        cand2     = inc3(cand1);
        if (state_q == ST_OWNED) begin
            req_ready = req_valid & oh3(owner_q);
            grant_idx = owner_q;
        end else if (|(req_valid & oh3(cand0))) begin
            req_ready = oh3(cand0);
            grant_idx = cand0;
        end else if (|(req_valid & oh3(cand1))) begin
            req_ready = oh3(cand1);
            grant_idx = cand1;
        end else if (|(req_valid & oh3(cand2))) begin
            req_ready = oh3(cand2);
            grant_idx = cand2;
        end
    end

    assign accept     = |req_ready;
    assign lock_sel   = |(req_lock & oh3(grant_idx));
    assign we_sel     = |(req_we & oh3(grant_idx));
    assign owner_lock = |(req_lock & oh3(owner_q));

    always_comb begin
        addr_sel  = req_addr[23:16];
        wdata_sel = req_wdata[23:16];
        case (grant_idx)
            2'd0: begin
                addr_sel  = req_addr[7:0];
                wdata_sel = req_wdata[7:0];
            end
            2'd1: begin
                addr_sel  = req_addr[15:8];
                wdata_sel = req_wdata[15:8];
            end
            default: ;
        endcase
    end

    // Dropping the lock releases ownership at this edge even if the owner is also accepted now.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_ARB: begin
                if (accept && lock_sel) begin
                    state_d = ST_OWNED;
                    owner_d = grant_idx;
                end
            end
            ST_OWNED: begin
                if (!owner_lock) state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge work_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            owner_q    <= 2'd0;
            rr_ptr_q   <= 2'd0;
            ce_q       <= 1'b0;
            wre_q      <= 1'b0;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            cram_idx_q <= 2'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ce_q    <= accept;
            wre_q   <= accept & we_sel;
            if (accept) begin
                rr_ptr_q   <= inc3(grant_idx);
                addr_q     <= addr_sel;
                data_q     <= wdata_sel;
                cram_idx_q <= grant_idx;
            end
        end
    end

    // Stage 0 captures the read on the edge that ends its BSRAM cycle, so the last stage lines up with cram_dataout.
    always_ff @(posedge work_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= '0;
            for (int k = 0; k < RD_LAT; k++) pend_idx_q[k] <= 2'd0;
        end else begin
            pend_vld_q[0] <= ce_q & ~wre_q;
            pend_idx_q[0] <= cram_idx_q;
            for (int k = 1; k < RD_LAT; k++) begin
                pend_vld_q[k] <= pend_vld_q[k-1];
                pend_idx_q[k] <= pend_idx_q[k-1];
            end
        end
    end

    assign rsp_valid   = pend_vld_q[RD_LAT-1] ? oh3(pend_idx_q[RD_LAT-1]) : 3'b000;
    assign rsp_data    = cram_dataout;
    assign cram_ce     = ce_q;
    assign cram_wre    = wre_q;
    assign cram_addrin = addr_q;
    assign cram_datain = data_q;
    assign busy        = ce_q | (|pend_vld_q);

endmodule

// File: tb/tb_cram_arbiter.sv
// Cycle-by-cycle vector bench for cram_arbiter (RD_LAT=1) plus a shadow RD_LAT=3 instance for latency and reset cases.
module tb_cram_arbiter;

    logic        work_clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid, req_we, req_lock;
    logic [23:0] req_addr, req_wdata;

    logic [2:0]  req_ready, rsp_valid;
    logic [7:0]  rsp_data, cram_addrin, cram_datain, cram_dataout;
    logic        cram_ce, cram_wre, busy;

    logic [2:0]  req_ready3, rsp_valid3;
    logic [7:0]  rsp_data3, cram_addrin3, cram_datain3, cram_dataout3;
    logic        cram_ce3, cram_wre3, busy3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 work_clk = ~work_clk;

    cram_arbiter #(.RD_LAT(1)) dut (
        .work_clk(work_clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .cram_ce(cram_ce), .cram_wre(cram_wre),
        .cram_addrin(cram_addrin), .cram_datain(cram_datain),
        .cram_dataout(cram_dataout), .busy(busy)
    );

    cram_arbiter #(.RD_LAT(3)) dut3 (
        .work_clk(work_clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
        .cram_ce(cram_ce3), .cram_wre(cram_wre3),
        .cram_addrin(cram_addrin3), .cram_datain(cram_datain3),
        .cram_dataout(cram_dataout3), .busy(busy3)
    );

    // BSRAM model: unwritten locations read as addr ^ 0xE0 (so 0x45 -> 0xA5).
    bit [7:0]   wmem [256];
    bit [255:0] wr_done;
    logic [7:0] rd1, r3a, r3b, r3c;

    function automatic logic [7:0] mem_rd(input logic [7:0] a);
        return wr_done[a] ? wmem[a] : (a ^ 8'hE0);
    endfunction

    always @(posedge work_clk) begin
        if (cram_ce) begin
            if (cram_wre) begin
                wmem[cram_addrin]    <= cram_datain;
                wr_done[cram_addrin] <= 1'b1;
            end else begin
                rd1 <= mem_rd(cram_addrin);
            end
        end
        if (cram_ce3 && !cram_wre3) r3a <= mem_rd(cram_addrin3);
        r3b <= r3a;
        r3c <= r3b;
    end

    assign cram_dataout  = rd1;
    assign cram_dataout3 = r3c;

    typedef struct {
        logic [2:0]  vld, we, lock;
        logic [23:0] addr, wdata;
        logic [2:0]  e_rdy;
        logic        e_ce, e_wre;
        logic [7:0]  e_addr, e_din;
        logic [2:0]  e_rspv;
        logic [7:0]  e_rspd;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];
    int   row_no;

    function automatic void row(input logic [2:0] vld, we, lock, input logic [23:0] addr, wdata,
                                input logic [2:0] e_rdy, input logic e_ce, e_wre,
                                input logic [7:0] e_addr, e_din, input logic [2:0] e_rspv,
                                input logic [7:0] e_rspd, input logic e_busy);
        vec_t v;
        v.vld = vld; v.we = we; v.lock = lock; v.addr = addr; v.wdata = wdata;
        v.e_rdy = e_rdy; v.e_ce = e_ce; v.e_wre = e_wre; v.e_addr = e_addr; v.e_din = e_din;
        v.e_rspv = e_rspv; v.e_rspd = e_rspd; v.e_busy = e_busy;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", name, row_no, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] vld, we, lock, input logic [23:0] addr, wdata);
        req_valid = vld; req_we = we; req_lock = lock; req_addr = addr; req_wdata = wdata;
    endtask

    initial begin
        rst_n  = 1'b0;
        row_no = -1;
        drive(3'b000, 3'b000, 3'b000, 24'h0, 24'h0);

        //   vld     we      lock    addr        wdata       rdy     ce wre addr   din    rspv    rspd   busy
        // all three reading, round-robin 0,1,2,0,1,2
        row(3'b111, 3'b000, 3'b000, 24'h201000, 24'h000000, 3'b001, 0, 0, 8'h00, 8'h00, 3'b000, 8'h00, 0);
        row(3'b111, 3'b000, 3'b000, 24'h201000, 24'h000000, 3'b010, 1, 0, 8'h00, 8'h00, 3'b000, 8'h00, 1);
        row(3'b111, 3'b000, 3'b000, 24'h201000, 24'h000000, 3'b100, 1, 0, 8'h10, 8'h00, 3'b001, 8'hE0, 1);
        row(3'b111, 3'b000, 3'b000, 24'h201000, 24'h000000, 3'b001, 1, 0, 8'h20, 8'h00, 3'b010, 8'hF0, 1);
        row(3'b111, 3'b000, 3'b000, 24'h201000, 24'h000000, 3'b010, 1, 0, 8'h00, 8'h00, 3'b100, 8'hC0, 1);
        row(3'b111, 3'b000, 3'b000, 24'h201000, 24'h000000, 3'b100, 1, 0, 8'h10, 8'h00, 3'b001, 8'hE0, 1);
        // drain, then idle with address held
        row(3'b000, 3'b000, 3'b000, 24'h201000, 24'h000000, 3'b000, 1, 0, 8'h20, 8'h00, 3'b010, 8'hF0, 1);
        row(3'b000, 3'b000, 3'b000, 24'h201000, 24'h000000, 3'b000, 0, 0, 8'h20, 8'h00, 3'b100, 8'hC0, 1);
        row(3'b000, 3'b000, 3'b000, 24'h201000, 24'h000000, 3'b000, 0, 0, 8'h20, 8'h00, 3'b000, 8'h00, 0);
        row(3'b000, 3'b000, 3'b000, 24'h201000, 24'h000000, 3'b000, 0, 0, 8'h20, 8'h00, 3'b000, 8'h00, 0);
        row(3'b000, 3'b000, 3'b000, 24'h201000, 24'h000000, 3'b000, 0, 0, 8'h20, 8'h00, 3'b000, 8'h00, 0);
        // requester 1 reads 0x45
        row(3'b010, 3'b000, 3'b000, 24'h004500, 24'h000000, 3'b010, 0, 0, 8'h20, 8'h00, 3'b000, 8'h00, 0);
        row(3'b000, 3'b000, 3'b000, 24'h004500, 24'h000000, 3'b000, 1, 0, 8'h45, 8'h00, 3'b000, 8'h00, 1);
        row(3'b000, 3'b000, 3'b000, 24'h004500, 24'h000000, 3'b000, 0, 0, 8'h45, 8'h00, 3'b010, 8'hA5, 1);
        row(3'b000, 3'b000, 3'b000, 24'h004500, 24'h000000, 3'b000, 0, 0, 8'h45, 8'h00, 3'b000, 8'h00, 0);
        // requester 2 writes 0xFF to 0xDF, requester 0 reads it back
        row(3'b100, 3'b100, 3'b000, 24'hDF0000, 24'hFF0000, 3'b100, 0, 0, 8'h45, 8'h00, 3'b000, 8'h00, 0);
        row(3'b001, 3'b000, 3'b000, 24'h0000DF, 24'h000000, 3'b001, 1, 1, 8'hDF, 8'hFF, 3'b000, 8'h00, 1);
        row(3'b000, 3'b000, 3'b000, 24'h0000DF, 24'h000000, 3'b000, 1, 0, 8'hDF, 8'h00, 3'b000, 8'h00, 1);
        row(3'b000, 3'b000, 3'b000, 24'h0000DF, 24'h000000, 3'b000, 0, 0, 8'hDF, 8'h00, 3'b001, 8'hFF, 1);
        row(3'b000, 3'b000, 3'b000, 24'h0000DF, 24'h000000, 3'b000, 0, 0, 8'hDF, 8'h00, 3'b000, 8'h00, 0);
        // requester 1 locks across read 0x02 and write 0x42; requester 2 waits for the release
        row(3'b110, 3'b000, 3'b010, 24'h000200, 24'h000000, 3'b010, 0, 0, 8'hDF, 8'h00, 3'b000, 8'h00, 0);
        row(3'b110, 3'b010, 3'b010, 24'h004200, 24'h007700, 3'b010, 1, 0, 8'h02, 8'h00, 3'b000, 8'h00, 1);
        row(3'b110, 3'b000, 3'b000, 24'h000300, 24'h000000, 3'b010, 1, 1, 8'h42, 8'h77, 3'b010, 8'hE2, 1);
        row(3'b100, 3'b000, 3'b000, 24'h050000, 24'h000000, 3'b100, 1, 0, 8'h03, 8'h00, 3'b000, 8'h00, 1);
        row(3'b000, 3'b000, 3'b000, 24'h050000, 24'h000000, 3'b000, 1, 0, 8'h05, 8'h00, 3'b010, 8'hE3, 1);
        row(3'b000, 3'b000, 3'b000, 24'h050000, 24'h000000, 3'b000, 0, 0, 8'h05, 8'h00, 3'b100, 8'hE5, 1);
        row(3'b000, 3'b000, 3'b000, 24'h050000, 24'h000000, 3'b000, 0, 0, 8'h05, 8'h00, 3'b000, 8'h00, 0);

        // reset state
        @(negedge work_clk);
        #1;
        chk("rst_ce", cram_ce, 1'b0);
        chk("rst_wre", cram_wre, 1'b0);
        chk("rst_addrin", cram_addrin, 8'h00);
        chk("rst_datain", cram_datain, 8'h00);
        chk("rst_rsp_valid", rsp_valid, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready_idle", req_ready, 3'b000);
        req_valid = 3'b111;
        #1;
        chk("rst_ready_all", req_ready, 3'b001);
        req_valid = 3'b000;
        @(negedge work_clk);
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            row_no = k;
            drive(tbl[k].vld, tbl[k].we, tbl[k].lock, tbl[k].addr, tbl[k].wdata);
            #1;
            chk("req_ready", req_ready, tbl[k].e_rdy);
            chk("cram_ce", cram_ce, tbl[k].e_ce);
            chk("cram_wre", cram_wre, tbl[k].e_wre);
            chk("cram_addrin", cram_addrin, tbl[k].e_addr);
            chk("cram_datain", cram_datain, tbl[k].e_din);
            chk("rsp_valid", rsp_valid, tbl[k].e_rspv);
            if (tbl[k].e_rspv != 3'b000) chk("rsp_data", rsp_data, tbl[k].e_rspd);
            chk("busy", busy, tbl[k].e_busy);
            @(negedge work_clk);
        end

        // RD_LAT=3: read of 0x10 by requester 0, response three cycles after the BSRAM cycle
        row_no = 100;
        drive(3'b001, 3'b000, 3'b000, 24'h000010, 24'h0);
        #1 chk("lat3_ready", req_ready3, 3'b001);
        @(negedge work_clk);
        req_valid = 3'b000;
        #1 chk("lat3_ce", cram_ce3, 1'b1);
        chk("lat3_addrin", cram_addrin3, 8'h10);
        @(negedge work_clk);
        #1 chk("lat3_ce_off", cram_ce3, 1'b0);
        chk("lat3_busy_pend", busy3, 1'b1);
        chk("lat3_rsp_early1", rsp_valid3, 3'b000);
        @(negedge work_clk);
        #1 chk("lat3_rsp_early2", rsp_valid3, 3'b000);
        @(negedge work_clk);
        #1 chk("lat3_rsp_valid", rsp_valid3, 3'b001);
        chk("lat3_rsp_data", rsp_data3, 8'hF0);
        chk("lat3_busy_last", busy3, 1'b1);
        @(negedge work_clk);
        #1 chk("lat3_rsp_done", rsp_valid3, 3'b000);
        chk("lat3_busy_done", busy3, 1'b0);

        // reset while a read is pending
        row_no = 200;
        drive(3'b001, 3'b000, 3'b000, 24'h000011, 24'h0);
        @(negedge work_clk);
        req_valid = 3'b000;
        #1 chk("mid_ce", cram_ce3, 1'b1);
        @(negedge work_clk);
        #1 chk("mid_busy", busy3, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_ce3", cram_ce3, 1'b0);
        chk("arst_busy3", busy3, 1'b0);
        chk("arst_addr3", cram_addrin3, 8'h00);
        chk("arst_rsp3", rsp_valid3, 3'b000);
        chk("arst_ce", cram_ce, 1'b0);
        chk("arst_busy", busy, 1'b0);
        @(negedge work_clk);
        @(negedge work_clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            row_no = 300 + c;
            #1;
            chk("post_rst_rsp3", rsp_valid3, 3'b000);
            chk("post_rst_rsp", rsp_valid, 3'b000);
            chk("post_rst_busy3", busy3, 1'b0);
            @(negedge work_clk);
        end
        row_no = 400;
        drive(3'b111, 3'b000, 3'b000, 24'h332211, 24'h0);
        #1 chk("post_rst_grant3", req_ready3, 3'b001);
        chk("post_rst_grant", req_ready, 3'b001);
        @(negedge work_clk);
        req_valid = 3'b000;
        #1 chk("post_rst_ce3", cram_ce3, 1'b1);
        chk("post_rst_addr3", cram_addrin3, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
